// File: rtl/cpu7_exu_byplog_multi_pkg.sv
// Shared constants for the EX-stage bypass unit: default sizes and byp_sel bit positions.
package cpu7_exu_byplog_multi_pkg;

    localparam int BYP_DEF_AW         = 5;
    localparam int BYP_DEF_NUM_STAGES = 2;

    localparam int BYP_SEL_RF = 0;
    localparam int BYP_SEL_M  = 1;
    localparam int BYP_SEL_W  = 2;

endpackage

// File: rtl/cpu7_exu_byplog_port.sv
// Per-operand match against the tracked post-EX stages plus youngest-first priority encoder.
module cpu7_exu_byplog_port
    import cpu7_exu_byplog_multi_pkg::*;
#(
    parameter int NUM_STAGES = BYP_DEF_NUM_STAGES,
    parameter int AW         = BYP_DEF_AW
) (
    input  logic [AW-1:0]            rs,
    input  logic                     rs_vld,
    input  logic [NUM_STAGES-1:0]    wen_q,
    input  logic [NUM_STAGES*AW-1:0] rd_q,
    output logic [NUM_STAGES:0]      sel
);

    logic found_s;
    logic hit_s;

    // Lowest stage index is the youngest producer, so the first hit wins; r0 never matches.
    always_comb begin
        sel     = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            hit_s = rs_vld & wen_q[k] & (rs == rd_q[k*AW +: AW]) & (rs != '0);
            if (hit_s && !found_s) begin
                sel[k+1] = 1'b1;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
        if (!found_s) begin
            sel[BYP_SEL_RF] = 1'b1;
        end else begin
            sel[BYP_SEL_RF] = 1'b0;
        end
    end

endmodule

// File: rtl/cpu7_exu_byplog_multi.sv
// EX-stage forwarding unit with tag pipeline and load-use interlock.
// Optional macro CPU7_BYP_LOAD_STALL_EN enables the load tag and the stall request.
module cpu7_exu_byplog_multi
    import cpu7_exu_byplog_multi_pkg::*;
#(
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_STAGES   = BYP_DEF_NUM_STAGES,
    parameter int AW           = BYP_DEF_AW
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_RD_PORTS*AW-1:0]           rs_e,
    input  logic [NUM_RD_PORTS-1:0]              rs_vld_e,
    input  logic [AW-1:0]                        rd_e,
    input  logic                                 wen_e,
    input  logic                                 is_load_e,
    input  logic                                 valid_e,
    input  logic                                 hold,
    input  logic                                 flush,
    output logic [NUM_RD_PORTS*(NUM_STAGES+1)-1:0] byp_sel,
    output logic                                 stall_req
);

    logic [NUM_STAGES-1:0][AW-1:0] rd_q;
    logic [NUM_STAGES-1:0]         wen_q;
    logic [NUM_STAGES-1:0]         fwd_en_s;
    logic                          stall_s;

`ifdef CPU7_BYP_LOAD_STALL_EN
    logic [NUM_STAGES-1:0]         ld_q;

    // Tag pipe: stage 0 here is M; a stall inserts a bubble while older stages drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wen_q <= '0;
            ld_q  <= '0;
        end else if (flush) begin
            wen_q <= '0;
            ld_q  <= '0;
        end else if (!hold) begin
            rd_q[0]  <= rd_e;
            wen_q[0] <= wen_e & valid_e & ~stall_s;
            ld_q[0]  <= is_load_e & wen_e & valid_e & ~stall_s;
            for (int k = 1; k < NUM_STAGES; k++) begin
                rd_q[k]  <= rd_q[k-1];
                wen_q[k] <= wen_q[k-1];
                ld_q[k]  <= ld_q[k-1];
            end
        end
    end

    // Load data is not ready in M: block M forwarding of a load and request an interlock.
    always_comb begin
        fwd_en_s    = wen_q;
        fwd_en_s[0] = wen_q[0] & ~ld_q[0];
        stall_s     = 1'b0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            stall_s = stall_s | (rs_vld_e[p] & wen_q[0] & ld_q[0] &
                                 (rs_e[p*AW +: AW] == rd_q[0]) & (rs_e[p*AW +: AW] != '0));
        end
    end

    logic unused_s;
    assign unused_s = 1'b0;
`else
    // Tag pipe without load tracking: loads forward from M like ALU results.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wen_q <= '0;
        end else if (flush) begin
            wen_q <= '0;
        end else if (!hold) begin
            rd_q[0]  <= rd_e;
            wen_q[0] <= wen_e & valid_e;
            for (int k = 1; k < NUM_STAGES; k++) begin
                rd_q[k]  <= rd_q[k-1];
                wen_q[k] <= wen_q[k-1];
            end
        end
    end

    assign fwd_en_s = wen_q;
    assign stall_s  = 1'b0;

    logic unused_s;
    assign unused_s = is_load_e;
`endif

    assign stall_req = stall_s;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        cpu7_exu_byplog_port #(
            .NUM_STAGES (NUM_STAGES),
            .AW         (AW)
        ) u_port (
            .rs     (rs_e[p*AW +: AW]),
            .rs_vld (rs_vld_e[p]),
            .wen_q  (fwd_en_s),
            .rd_q   (rd_q),
            .sel    (byp_sel[p*(NUM_STAGES+1) +: (NUM_STAGES+1)])
        );
    end

endmodule

// File: tb/tb_cpu7_exu_byplog_multi.sv
// Directed scoreboard bench for cpu7_exu_byplog_multi (2 ports, 2 stages, AW = 5).
module tb_cpu7_exu_byplog_multi;

    localparam logic [2:0] RF = 3'b001;
    localparam logic [2:0] M  = 3'b010;
    localparam logic [2:0] W  = 3'b100;
`ifdef CPU7_BYP_LOAD_STALL_EN
    localparam logic       LS     = 1'b1;
    localparam logic [2:0] LD_M   = RF;
`else
    localparam logic       LS     = 1'b0;
    localparam logic [2:0] LD_M   = M;
`endif

    typedef struct packed {
        logic [5:0] sel;
        logic       stall;
        logic [7:0] id;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  rs_e = '0;
    logic [1:0]  rs_vld_e = '0;
    logic [4:0]  rd_e = 5'd3;
    logic        wen_e = 1'b1;
    logic        is_load_e = 1'b0;
    logic        valid_e = 1'b1;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  byp_sel;
    logic        stall_req;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   step_id = 0;

    cpu7_exu_byplog_multi #(.NUM_RD_PORTS(2), .NUM_STAGES(2), .AW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_e      (rs_e),
        .rs_vld_e  (rs_vld_e),
        .rd_e      (rd_e),
        .wen_e     (wen_e),
        .is_load_e (is_load_e),
        .valid_e   (valid_e),
        .hold      (hold),
        .flush     (flush),
        .byp_sel   (byp_sel),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are settled mid-cycle, so compare one queued expectation per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (byp_sel !== e.sel || stall_req !== e.stall) begin
                n_err++;
                $display("FAIL step%0d: byp_sel=%b stall_req=%b, expected byp_sel=%b stall_req=%b",
                         e.id, byp_sel, stall_req, e.sel, e.stall);
            end
        end
    end

    task automatic step(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [1:0] vld, input logic [4:0] rd, input logic w,
                        input logic ld, input logic v, input logic h, input logic f,
                        input logic chk, input logic [2:0] e0, input logic [2:0] e1,
                        input logic est);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        rs_e      = {r2, r1};
        rs_vld_e  = vld;
        rd_e      = rd;
        wen_e     = w;
        is_load_e = ld;
        valid_e   = v;
        hold      = h;
        flush     = f;
        step_id++;
        if (chk) begin
            e.sel   = {e1, e0};
            e.stall = est;
            e.id    = 8'(step_id);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        //   rst  rs1    rs2    vld    rd     w     ld    v     h     f     chk   e0  e1  stall
        // Reset held with a writer present; state cleared by the first edge.
        step(1'b1, 5'd3, 5'd3, 2'b11, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RF, RF, 1'b0);
        step(1'b0, 5'd3, 5'd3, 2'b11, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RF, RF, 1'b0);
        step(1'b0, 5'd3, 5'd3, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, M,  M,  1'b0);
        // ALU chain on r5 while r3 ages into W.
        step(1'b0, 5'd3, 5'd3, 2'b11, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, W,  W,  1'b0);
        step(1'b0, 5'd5, 5'd5, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, M,  M,  1'b0);
        step(1'b0, 5'd5, 5'd5, 2'b11, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, W,  W,  1'b0);
        // r7 written twice: youngest (M) wins; rs2 unread -> RF.
        step(1'b0, 5'd7, 5'd7, 2'b01, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, M,  RF, 1'b0);
        step(1'b0, 5'd7, 5'd7, 2'b11, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, M,  M,  1'b0);
        // r0 in M never forwards; r7 still reachable in W. EX writer of r6 is invalid.
        step(1'b0, 5'd0, 5'd7, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RF, W,  1'b0);
        step(1'b0, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RF, RF, 1'b0);
        // Load to r9 followed by a dependent read on rs2.
        step(1'b0, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, RF, RF, 1'b0);
        step(1'b0, 5'd0, 5'd9, 2'b10, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RF, LD_M, LS);
        step(1'b0, 5'd0, 5'd9, 2'b10, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RF, W,  1'b0);
        // Flush together with hold wins over hold.
        step(1'b0, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RF, RF, 1'b0);
        step(1'b0, 5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, M,  RF, 1'b0);
        step(1'b0, 5'd4, 5'd0, 2'b01, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RF, RF, 1'b0);
        // Hold for three cycles with a competing writer at EX: r4 stays in M.
        step(1'b0, 5'd4, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, M,  RF, 1'b0);
        step(1'b0, 5'd4, 5'd8, 2'b11, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, M,  RF, 1'b0);
        step(1'b0, 5'd4, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, M,  RF, 1'b0);
        step(1'b0, 5'd4, 5'd0, 2'b01, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, M,  RF, 1'b0);
        step(1'b0, 5'd4, 5'd2, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, W,  M,  1'b0);
        // Reset mid-operation clears r2 (now in W) and r4.
        step(1'b1, 5'd2, 5'd4, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, W,  RF, 1'b0);
        step(1'b0, 5'd2, 5'd4, 2'b11, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, RF, RF, 1'b0);
        // Load to r11 under hold: interlock request persists while frozen.
        step(1'b0, 5'd11, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, LD_M, RF, LS);
        step(1'b0, 5'd11, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, LD_M, RF, LS);
        step(1'b0, 5'd11, 5'd11, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, W,  W,  1'b0);
        step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RF, RF, 1'b0);
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
